// File: rtl/ram_sequencer.sv
// ram_sequencer: burst command front end driving the Hack data RAM load/address/data port
module ram_sequencer #(
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_base_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic [15:0]       wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [15:0]       rd_data_o,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_load_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [15:0]       mem_data_out_o,
  input  logic [15:0]       mem_data_in_i
);
  localparam int D = RD_LAT + 1;
  localparam int PW = $clog2(D);
  localparam int CW = $clog2(D + 1);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, rem_q, rem_d, mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic mem_load_q, mem_load_d, done_q, done_d;
  logic [RD_LAT-1:0] pipe_q;
  logic [15:0] fifo_q [D];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] in_flight, occ;
  logic issue, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(D - 1) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + 4'(pipe_q[i]);
  end
  assign push = pipe_q[RD_LAT-1];
  assign pop = rd_valid_o && rd_ready_i;
  // a slot freed by this cycle's pop may be reused, keeping reads at one word per cycle
  assign occ = in_flight + 4'(cnt_q) - 4'(pop);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_load_d = 1'b0;
    done_d = 1'b0;
    issue = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d = cmd_write_i ? WRITE : READ;
        addr_d = cmd_base_i;
        rem_d = cmd_len_i;
      end
      WRITE: if (wr_valid_i) begin
        mem_load_d = 1'b1;
        mem_addr_d = addr_q;
        mem_data_d = wr_data_i;
        addr_d = addr_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        state_d = rem_q == '0 ? IDLE : WRITE;
        done_d = rem_q == '0;
      end
      READ: if (occ < 4'(D)) begin
        issue = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        state_d = rem_q == '0 ? DRAIN : READ;
      end
      default: if (in_flight == '0 && cnt_q == '0) begin
        state_d = IDLE;
        done_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_load_q <= 1'b0;
      done_q <= 1'b0;
      pipe_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < D; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_load_q <= mem_load_d;
      done_q <= done_d;
      pipe_q <= RD_LAT'({pipe_q, issue});
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_data_in_i;
        wr_ptr_q <= nxt(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= nxt(rd_ptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
  assign cmd_ready_o = state_q == IDLE;
  assign busy_o = state_q != IDLE;
  assign wr_ready_o = state_q == WRITE;
  assign rd_valid_o = cnt_q != '0;
  assign rd_data_o = fifo_q[rd_ptr_q];
  assign done_o = done_q;
  assign mem_load_o = mem_load_q;
  assign mem_data_out_o = mem_data_q;
  assign mem_address_o = mem_load_q ? mem_addr_q : addr_q;
endmodule

// File: tb/tb_ram_sequencer.sv
// tb_ram_sequencer: randomized bursts checked against an address-indexed shadow memory model
module tb_ram_sequencer;
  localparam int AW = 7;
  localparam int LAT = 1;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, cmd_ready;
  logic [AW-1:0] cmd_base = '0, cmd_len = '0;
  logic [15:0] wr_data = '0, rd_data, mem_data_out, mem_data_in;
  logic wr_valid = 1'b0, wr_ready, rd_valid, rd_ready = 1'b0;
  logic busy, done, mem_load;
  logic [AW-1:0] mem_address;
  logic [15:0] ram [DEPTH];
  logic [15:0] rpipe [LAT];
  logic [15:0] model [DEPTH];
  logic [15:0] wq [$];
  bit hold = 1'b0;
  int total = 0, bad = 0;
  ram_sequencer #(.ADDR_W(AW), .RD_LAT(LAT)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_base_i(cmd_base), .cmd_len_i(cmd_len),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .busy_o(busy), .done_o(done),
    .mem_load_o(mem_load), .mem_address_o(mem_address),
    .mem_data_out_o(mem_data_out), .mem_data_in_i(mem_data_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_load) ram[mem_address] <= mem_data_out;
    rpipe[0] <= ram[mem_address];
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_data_in = rpipe[LAT-1];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_wr_ready"}, wr_ready, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mem_load"}, mem_load, 0);
    check({tag, "_mem_addr"}, mem_address, 0);
    check({tag, "_mem_dout"}, mem_data_out, 0);
  endtask
  task automatic start_cmd(input bit w, input int base, input int len);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_base = AW'(base);
    cmd_len = AW'(len);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask
  task automatic do_write(input int base, input int len, input bit gaps);
    int pend, i, viol;
    bit acc;
    start_cmd(1'b1, base, len);
    if (hold) begin
      cmd_write = 1'b0;
      cmd_base = '0;
      cmd_len = AW'(DEPTH - 1);
    end
    pend = -1;
    i = 0;
    viol = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (pend >= 0) begin
        check("wr_load", mem_load, 1);
        check("wr_addr", mem_address, (base + pend) % DEPTH);
        check("wr_data", mem_data_out, wq[pend]);
        check("wr_done", done, pend == len);
        if (pend == len) break;
      end else begin
        check("wr_noload", mem_load, 0);
        check("wr_done_early", done, 0);
      end
      if (cmd_ready) viol++;
      wr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data = wq[i];
      acc = wr_valid && wr_ready;
      if (acc) model[(base + i) % DEPTH] = wq[i];
      pend = acc ? i : -1;
      i += int'(acc);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("wr_words", i, len + 1);
    check("wr_held_cmd", viol, 0);
    check("wr_busy_end", busy, 0);
  endtask
  task automatic do_read(input int base, input int len, input int mode);
    int got = 0, first = -1, f_hs = -1, l_hs = -1, k = 0, t;
    bit dn = 1'b0;
    logic [5:0] pat = 6'b101001;
    start_cmd(1'b0, base, len);
    for (t = 0; t < 4000; t++) begin
      if (rd_valid && first < 0) first = t;
      if (done) begin
        dn = 1'b1;
        break;
      end
      rd_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[k % 6] : 1'($urandom_range(0, 1));
      if (rd_valid) k++;
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, model[(base + got) % DEPTH]);
        if (f_hs < 0) f_hs = t;
        l_hs = t;
        got++;
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check("rd_done_seen", dn, 1);
    check("rd_words", got, len + 1);
    check("rd_first_valid", first, LAT + 1);
    check("rd_done_lag", t, l_hs + 2);
    check("rd_valid_after", rd_valid, 0);
    check("rd_busy_after", busy, 0);
    if (mode == 0) check("rd_rate", l_hs - f_hs, len);
  endtask
  task automatic load_words(input int first, input int n);
    wq.delete();
    for (int k = 0; k < n; k++) wq.push_back(16'(first + k));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("reset");
    wq = {16'd57, 16'd1, 16'd9};
    do_write(5, 2, 1'b0);
    do_read(5, 2, 0);
    do_read(5, 2, 1);
    load_words(10, 4);
    do_write(126, 3, 1'b0);
    do_read(126, 3, 0);
    for (int r = 0; r < 6; r++) begin
      int b = $urandom_range(0, DEPTH - 1);
      int l = $urandom_range(0, 12);
      wq.delete();
      for (int k = 0; k <= l; k++) wq.push_back(16'($urandom));
      do_write(b, l, 1'b1);
      do_read(b, l, 2);
    end
    load_words(100, 11);
    start_cmd(1'b1, 20, 10);
    wr_valid = 1'b1;
    wr_data = 16'hBEEF;
    repeat (3) @(negedge clk);
    check("rst_pre_load", mem_load, 1);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    hold = 1'b1;
    load_words(0, DEPTH);
    do_write(0, DEPTH - 1, 1'b0);
    hold = 1'b0;
    do_read(0, DEPTH - 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
